// File: rtl/serial_pkt_pkg.sv
// Shared definitions for the serial packet transmitter and its receiver.
// Field widths, FSM state encoding and the idle line level.
package serial_pkt_pkg;

   localparam int PORT_W = 2;
   localparam int CNT_W = 4;
   localparam int DATA_W = 15;
   localparam logic IDLE_LVL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      PORT,
      COUNT,
      DATA,
      PAR
   } tx_state_t;

endpackage

// File: rtl/serial_packet_tx_bit_counter.sv
// Loadable down-counter used to index the port, count and payload fields.
// Load wins over decrement; the count stops at zero.
module tx_bit_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clk_en,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] cnt,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clk_en) begin
         if (load) begin
            cnt <= load_val;
         end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
         end
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/serial_packet_tx.sv
// Serial packet transmitter: start bit, port, count, payload, MSB first.
// Optional trailing even-parity bit with `define SERIAL_TX_PARITY_EN.
module serial_packet_tx #(
   parameter int PORT_W = 2,
   parameter int CNT_W = 4,
   parameter int DATA_W = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              start,
   input  logic [PORT_W-1:0] port_num,
   input  logic [CNT_W-1:0]  num_data,
   input  logic [DATA_W-1:0] data,
   output logic              serout,
   output logic              busy,
   output logic              done
);

   import serial_pkt_pkg::*;

`ifdef SERIAL_TX_PARITY_EN
   localparam tx_state_t LAST_ST = PAR;
`else
   localparam tx_state_t LAST_ST = IDLE;
`endif

   tx_state_t         state_q;
   tx_state_t         state_n;
   logic [PORT_W-1:0] port_q;
   logic [CNT_W-1:0]  num_q;
   logic [DATA_W-1:0] data_q;
   logic              serout_q;
   logic              serout_n;
   logic              busy_q;
   logic              busy_n;
   logic              done_q;
   logic              done_n;
   logic              cap;
   logic              ld;
   logic              dec;
   logic [CNT_W-1:0]  ld_val;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  sel;
   logic              zero;
   logic              fbit;

   tx_bit_counter #(
      .W(CNT_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clk_en   (clk_en),
      .load     (ld),
      .dec      (dec),
      .load_val (ld_val),
      .cnt      (cnt),
      .zero     (zero)
   );

   always_comb begin
      state_n = state_q;
      cap = 1'b0;
      ld = 1'b0;
      dec = 1'b0;
      ld_val = '0;
      if (clk_en) begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  cap = 1'b1;
                  state_n = START;
               end
            end
            START: begin
               state_n = PORT;
               ld = 1'b1;
               ld_val = CNT_W'(PORT_W - 1);
            end
            PORT: begin
               if (zero) begin
                  state_n = COUNT;
                  ld = 1'b1;
                  ld_val = CNT_W'(CNT_W - 1);
               end else begin
                  dec = 1'b1;
               end
            end
            COUNT: begin
               if (!zero) begin
                  dec = 1'b1;
               end else if (num_q != '0) begin
                  state_n = DATA;
                  ld = 1'b1;
                  ld_val = num_q - CNT_W'(1);
               end else begin
                  state_n = LAST_ST;
               end
            end
            DATA: begin
               if (!zero) begin
                  dec = 1'b1;
               end else begin
                  state_n = LAST_ST;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // The counter value always names the bit currently on the line,
   // so the next bit is the loaded index or the one below it.
   always_comb begin
      sel = ld ? ld_val : (cnt - CNT_W'(1));
      fbit = 1'b0;
      for (int i = 0; i < PORT_W; i++) begin
         if (state_n == PORT && sel == CNT_W'(i)) fbit = port_q[i];
      end
      for (int i = 0; i < CNT_W; i++) begin
         if (state_n == COUNT && sel == CNT_W'(i)) fbit = num_q[i];
      end
      for (int i = 0; i < DATA_W; i++) begin
         if (state_n == DATA && sel == CNT_W'(i)) fbit = data_q[i];
      end
   end

   always_comb begin
      serout_n = serout_q;
      busy_n = (state_n != IDLE);
      done_n = clk_en && (state_q != IDLE) && (state_n == IDLE);
      if (clk_en) begin
         unique case (state_n)
            START: serout_n = 1'b0;
            PORT, COUNT, DATA: serout_n = fbit;
`ifdef SERIAL_TX_PARITY_EN
            PAR: serout_n = ^(data_q &
               ((DATA_W'(1) << num_q) - DATA_W'(1)));
`endif
            default: serout_n = IDLE_LVL;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         serout_q <= IDLE_LVL;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         port_q <= '0;
         num_q <= '0;
         data_q <= '0;
      end else begin
         state_q <= state_n;
         serout_q <= serout_n;
         busy_q <= busy_n;
         done_q <= done_n;
         if (cap) begin
            port_q <= port_num;
            num_q <= num_data;
            data_q <= data;
         end
      end
   end

   assign serout = serout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
